// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared opcodes, state encoding and control-field encodings
// for the multi-cycle MIPS-lite control sequencer.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] F_NOP  = 6'h00;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUBU = 6'h23;

    // FETCH is all-zero so the debug state port reads 0 while in reset
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXE_R, S_WB_R, S_EXE_ORI, S_WB_I, S_LUI, S_MEM_ADR,
        S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_JAL, S_JR, S_ILL
    } state_t;

    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_OR, ALU_RSV} alu_ctr_t;
    typedef enum logic [1:0] {A3_RT, A3_RD, A3_RA, A3_RSV} a3_sel_t;
    typedef enum logic [1:0] {WD_ALU, WD_MDR, WD_LUI, WD_PC} wd_sel_t;
    typedef enum logic [1:0] {B_REG, B_FOUR, B_IMM, B_IMM_SL2} alu_b_sel_t;
    typedef enum logic [1:0] {PC_ALU, PC_ALUOUT, PC_JUMP, PC_REG} pc_src_t;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       pc_we;
        logic       ir_we;
        logic       grf_we;
        logic       dm_we;
        logic       byte_sel;
        a3_sel_t    a3_sel;
        wd_sel_t    wd_sel;
        logic       alu_a_sel;
        alu_b_sel_t alu_b_sel;
        alu_ctr_t   alu_ctr;
        logic       ext_op;
        pc_src_t    pc_src;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/mc_control_fsm_decode.sv
// mc_decode: combinational op/funct to post-DECODE dispatch state.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output state_t     next_o
);

    always_comb begin
        next_o = S_ILL;
        case (op_i)
            OP_RTYPE: next_o = (funct_i == F_ADDU || funct_i == F_SUBU || funct_i == F_NOP) ? S_EXE_R :
                               (funct_i == F_JR) ? S_JR : S_ILL;
            OP_ORI:                      next_o = S_EXE_ORI;
            OP_LUI:                      next_o = S_LUI;
            OP_LW, OP_SW, OP_LB, OP_SB:  next_o = S_MEM_ADR;
            OP_BEQ:                      next_o = S_BRANCH;
            OP_J:                        next_o = S_JUMP;
            OP_JAL:                      next_o = S_JAL;
            default:                     next_o = S_ILL;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle control sequencer for the MIPS-lite datapath,
// with memory request handshake, sticky illegal flag and retire counter.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             iord,
    output logic             pc_we,
    output logic             ir_we,
    output logic             grf_we,
    output logic             dm_we,
    output logic             byte_sel,
    output logic [1:0]       a3_sel,
    output logic [1:0]       wd_sel,
    output logic             alu_a_sel,
    output logic [1:0]       alu_b_sel,
    output logic [1:0]       alu_ctr,
    output logic             ext_op,
    output logic [1:0]       pc_src,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [3:0]       state
);

    state_t            state_q, state_d, dec_state;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              illegal_q, illegal_d;
    ctrl_t             c, co;

    mc_decode u_decode (
        .op_i    (op),
        .funct_i (funct),
        .next_o  (dec_state)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        c       = '0;
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_b_sel = B_FOUR;
                c.ir_we     = mem_ready;
                c.pc_we     = mem_ready;
                state_d     = mem_ready ? S_DECODE : S_FETCH;
            end
            // branch target PC+4+(imm<<2) is precomputed here into ALUOut
            S_DECODE: begin
                c.alu_b_sel = B_IMM_SL2;
                c.ext_op    = 1'b1;
                state_d     = dec_state;
            end
            S_EXE_R: begin
                c.alu_a_sel = 1'b1;
                c.alu_ctr   = (funct == F_SUBU) ? ALU_SUB : ALU_ADD;
                state_d     = S_WB_R;
            end
            // funct 0 is the nop encoding: walk the R path but never write
            S_WB_R: begin
                c.grf_we     = (funct != F_NOP);
                c.a3_sel     = A3_RD;
                c.instr_done = 1'b1;
                state_d      = S_FETCH;
            end
            S_EXE_ORI: begin
                c.alu_a_sel = 1'b1;
                c.alu_b_sel = B_IMM;
                c.alu_ctr   = ALU_OR;
                state_d     = S_WB_I;
            end
            S_WB_I: begin
                c.grf_we     = 1'b1;
                c.instr_done = 1'b1;
                state_d      = S_FETCH;
            end
            S_LUI: begin
                c.grf_we     = 1'b1;
                c.wd_sel     = WD_LUI;
                c.instr_done = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEM_ADR: begin
                c.alu_a_sel = 1'b1;
                c.alu_b_sel = B_IMM;
                c.ext_op    = 1'b1;
                state_d     = (op == OP_LW || op == OP_LB) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                c.mem_req  = 1'b1;
                c.iord     = 1'b1;
                c.byte_sel = (op == OP_LB);
                state_d    = mem_ready ? S_WB_MEM : S_MEM_RD;
            end
            S_WB_MEM: begin
                c.grf_we     = 1'b1;
                c.wd_sel     = WD_MDR;
                c.byte_sel   = (op == OP_LB);
                c.instr_done = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEM_WR: begin
                c.mem_req    = 1'b1;
                c.dm_we      = 1'b1;
                c.iord       = 1'b1;
                c.byte_sel   = (op == OP_SB);
                c.instr_done = mem_ready;
                state_d      = mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_BRANCH: begin
                c.alu_a_sel  = 1'b1;
                c.alu_ctr    = ALU_SUB;
                c.pc_src     = PC_ALUOUT;
                c.pc_we      = zero;
                c.instr_done = 1'b1;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                c.pc_we      = 1'b1;
                c.pc_src     = PC_JUMP;
                c.instr_done = 1'b1;
                state_d      = S_FETCH;
            end
            // PC already holds PC+4, so it is the link value
            S_JAL: begin
                c.pc_we      = 1'b1;
                c.pc_src     = PC_JUMP;
                c.grf_we     = 1'b1;
                c.a3_sel     = A3_RA;
                c.wd_sel     = WD_PC;
                c.instr_done = 1'b1;
                state_d      = S_FETCH;
            end
            S_JR: begin
                c.pc_we      = 1'b1;
                c.pc_src     = PC_REG;
                c.instr_done = 1'b1;
                state_d      = S_FETCH;
            end
            S_ILL: begin
                c.instr_done = 1'b1;
                state_d      = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign cnt_d     = c.instr_done ? cnt_q + CNT_W'(1) : cnt_q;
    assign illegal_d = illegal_q | (state_q == S_ILL);

    // all control is forced quiet while reset is asserted
    assign co         = reset ? '0 : c;
    assign mem_req    = co.mem_req;
    assign iord       = co.iord;
    assign pc_we      = co.pc_we;
    assign ir_we      = co.ir_we;
    assign grf_we     = co.grf_we;
    assign dm_we      = co.dm_we;
    assign byte_sel   = co.byte_sel;
    assign a3_sel     = co.a3_sel;
    assign wd_sel     = co.wd_sel;
    assign alu_a_sel  = co.alu_a_sel;
    assign alu_b_sel  = co.alu_b_sel;
    assign alu_ctr    = co.alu_ctr;
    assign ext_op     = co.ext_op;
    assign pc_src     = co.pc_src;
    assign instr_done = co.instr_done;
    assign illegal    = ~reset & (illegal_q | (state_q == S_ILL));
    assign instr_cnt  = cnt_q;
    assign state      = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed plus randomized instruction stream checked
// cycle by cycle against a per-instruction expected control schedule.
module tb_mc_control_fsm;
    import mc_ctrl_pkg::*;

    localparam int CW = 4;

    typedef struct packed {
        logic       mem_req, iord, pc_we, ir_we, grf_we, dm_we, byte_sel;
        logic [1:0] a3_sel, wd_sel;
        logic       alu_a_sel;
        logic [1:0] alu_b_sel, alu_ctr;
        logic       ext_op;
        logic [1:0] pc_src;
        logic       instr_done;
    } o_t;

    logic          clk = 1'b0;
    logic          reset, zero, mem_ready;
    logic [5:0]    op, funct;
    logic          mem_req, iord, pc_we, ir_we, grf_we, dm_we, byte_sel;
    logic [1:0]    a3_sel, wd_sel, alu_b_sel, alu_ctr, pc_src;
    logic          alu_a_sel, ext_op, instr_done, illegal;
    logic [CW-1:0] instr_cnt;
    logic [3:0]    state;

    int            n_assert = 0;
    int            n_fail = 0;
    logic [CW-1:0] cnt_m = '0;
    bit            ill_m = 1'b0;
    o_t            obs;

    always #5 clk = ~clk;

    mc_control_fsm #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord), .pc_we(pc_we),
        .ir_we(ir_we), .grf_we(grf_we), .dm_we(dm_we), .byte_sel(byte_sel),
        .a3_sel(a3_sel), .wd_sel(wd_sel), .alu_a_sel(alu_a_sel),
        .alu_b_sel(alu_b_sel), .alu_ctr(alu_ctr), .ext_op(ext_op),
        .pc_src(pc_src), .instr_done(instr_done), .illegal(illegal),
        .instr_cnt(instr_cnt), .state(state)
    );

    assign obs = {mem_req, iord, pc_we, ir_we, grf_we, dm_we, byte_sel, a3_sel, wd_sel,
                  alu_a_sel, alu_b_sel, alu_ctr, ext_op, pc_src, instr_done};

    function automatic bit rz();
        return 1'($urandom);
    endfunction

    function automatic bit legal_op(input logic [5:0] o);
        return o inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h0d, 6'h0f, 6'h20, 6'h23, 6'h28, 6'h2b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // one clock: drive, check settled outputs at negedge, advance past posedge
    task automatic step(input o_t e, input bit rdy, input bit z, input string tag);
        mem_ready = rdy;
        zero      = z;
        @(negedge clk);
        chk({tag, ".ctl"}, 32'(obs), 32'(e));
        chk({tag, ".cnt"}, 32'(instr_cnt), 32'(cnt_m));
        chk({tag, ".ill"}, 32'(illegal), 32'(ill_m));
        @(posedge clk);
        #1;
        if (e.instr_done) cnt_m++;
    endtask

    task automatic reset_now(input string tag);
        mem_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk({tag, ".ctl"}, 32'(obs), 32'd0);
        chk({tag, ".state"}, 32'(state), 32'(S_FETCH));
        chk({tag, ".cnt"}, 32'(instr_cnt), 32'd0);
        chk({tag, ".ill"}, 32'(illegal), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cnt_m = '0;
        ill_m = 1'b0;
    endtask

    // fw: fetch wait cycles, mw: data-memory wait cycles, rst_wait: reset during store wait
    task automatic run_instr(input logic [31:0] ir, input int fw, input int mw, input bit z,
                             input bit rst_wait, input string tag);
        logic [5:0] o, f;
        o_t e;
        o = ir[31:26];
        f = ir[5:0];
        op = o;
        funct = f;
        for (int i = 0; i < fw; i++) begin
            e = '0; e.mem_req = 1; e.alu_b_sel = 2'd1;
            step(e, 1'b0, rz(), {tag, ".fwait"});
        end
        e = '0; e.mem_req = 1; e.alu_b_sel = 2'd1; e.ir_we = 1; e.pc_we = 1;
        step(e, 1'b1, rz(), {tag, ".fetch"});
        e = '0; e.alu_b_sel = 2'd3; e.ext_op = 1;
        step(e, rz(), rz(), {tag, ".dec"});
        e = '0;
        if (o == 6'h00 && f inside {6'h21, 6'h23, 6'h00}) begin
            e.alu_a_sel = 1; e.alu_ctr = (f == 6'h23) ? 2'd1 : 2'd0;
            step(e, rz(), rz(), {tag, ".exe"});
            e = '0; e.grf_we = (f != 6'h00); e.a3_sel = 2'd1; e.instr_done = 1;
            step(e, rz(), rz(), {tag, ".wb"});
        end else if (o == 6'h00 && f == 6'h08) begin
            e.pc_we = 1; e.pc_src = 2'd3; e.instr_done = 1;
            step(e, rz(), rz(), {tag, ".jr"});
        end else if (o == 6'h0d) begin
            e.alu_a_sel = 1; e.alu_b_sel = 2'd2; e.alu_ctr = 2'd2;
            step(e, rz(), rz(), {tag, ".exe"});
            e = '0; e.grf_we = 1; e.instr_done = 1;
            step(e, rz(), rz(), {tag, ".wb"});
        end else if (o == 6'h0f) begin
            e.grf_we = 1; e.wd_sel = 2'd2; e.instr_done = 1;
            step(e, rz(), rz(), {tag, ".lui"});
        end else if (o == 6'h23 || o == 6'h20 || o == 6'h2b || o == 6'h28) begin
            e.alu_a_sel = 1; e.alu_b_sel = 2'd2; e.ext_op = 1;
            step(e, rz(), rz(), {tag, ".adr"});
            e = '0; e.mem_req = 1; e.iord = 1;
            e.dm_we = (o == 6'h2b || o == 6'h28);
            e.byte_sel = (o == 6'h20 || o == 6'h28);
            for (int i = 0; i < mw; i++) step(e, 1'b0, rz(), {tag, ".mwait"});
            if (e.dm_we && rst_wait) begin
                reset_now({tag, ".rst"});
                return;
            end
            e.instr_done = e.dm_we;
            step(e, 1'b1, rz(), {tag, ".mem"});
            if (!e.dm_we) begin
                e = '0; e.grf_we = 1; e.wd_sel = 2'd1; e.byte_sel = (o == 6'h20); e.instr_done = 1;
                step(e, rz(), rz(), {tag, ".wbm"});
            end
        end else if (o == 6'h04) begin
            e.alu_a_sel = 1; e.alu_ctr = 2'd1; e.pc_src = 2'd1; e.pc_we = z; e.instr_done = 1;
            step(e, rz(), z, {tag, ".beq"});
        end else if (o == 6'h02 || o == 6'h03) begin
            e.pc_we = 1; e.pc_src = 2'd2; e.instr_done = 1;
            if (o == 6'h03) begin e.grf_we = 1; e.a3_sel = 2'd2; e.wd_sel = 2'd3; end
            step(e, rz(), rz(), {tag, ".jmp"});
        end else begin
            ill_m = 1'b1;
            e.instr_done = 1;
            step(e, rz(), rz(), {tag, ".ill"});
        end
    endtask

    function automatic logic [31:0] mk(input int k);
        logic [31:0] r;
        r = $urandom;
        case (k)
            0: begin r[31:26] = 6'h00; r[5:0] = 6'h21; end
            1: begin r[31:26] = 6'h00; r[5:0] = 6'h23; end
            2: begin r[31:26] = 6'h00; r[5:0] = 6'h00; end
            3: begin r[31:26] = 6'h00; r[5:0] = 6'h08; end
            4: begin
                r[31:26] = 6'h00;
                do r[5:0] = 6'($urandom); while (r[5:0] inside {6'h00, 6'h08, 6'h21, 6'h23});
            end
            5:  r[31:26] = 6'h0d;
            6:  r[31:26] = 6'h0f;
            7:  r[31:26] = 6'h23;
            8:  r[31:26] = 6'h2b;
            9:  r[31:26] = 6'h20;
            10: r[31:26] = 6'h28;
            11: r[31:26] = 6'h04;
            12: r[31:26] = 6'h02;
            13: r[31:26] = 6'h03;
            default: do r[31:26] = 6'($urandom); while (legal_op(r[31:26]));
        endcase
        return r;
    endfunction

    initial begin
        reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; op = '0; funct = '0;
        #2;
        chk("por.ctl", 32'(obs), 32'd0);
        chk("por.state", 32'(state), 32'(S_FETCH));
        chk("por.cnt", 32'(instr_cnt), 32'd0);
        chk("por.ill", 32'(illegal), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_instr(32'h00221821, 0, 0, 1'b0, 1'b0, "addu");
        run_instr(32'h8C220004, 0, 2, 1'b0, 1'b0, "lw_wait");
        run_instr(32'h10220003, 0, 0, 1'b1, 1'b0, "beq_t");
        run_instr(32'h10220003, 0, 0, 1'b0, 1'b0, "beq_nt");
        run_instr(32'h0C000C00, 0, 0, 1'b0, 1'b0, "jal");
        run_instr(32'hFC000000, 0, 0, 1'b0, 1'b0, "ill");
        run_instr(32'h00221821, 1, 0, 1'b0, 1'b0, "addu_sticky");
        run_instr(32'hA0220001, 0, 1, 1'b0, 1'b0, "sb");
        run_instr(32'h80220001, 0, 0, 1'b0, 1'b0, "lb");
        run_instr(32'h00221823, 0, 0, 1'b0, 1'b0, "subu");
        run_instr(32'h00000000, 0, 0, 1'b0, 1'b0, "nop");
        run_instr(32'hAC220008, 0, 2, 1'b0, 1'b1, "sw_rst");
        run_instr(32'h00221821, 0, 0, 1'b0, 1'b0, "post_rst");
        for (int n = 0; n < 250; n++) begin
            int fw, mw;
            fw = ($urandom_range(3) == 0) ? int'($urandom_range(3, 1)) : 0;
            mw = ($urandom_range(2) == 0) ? int'($urandom_range(3, 1)) : 0;
            run_instr(mk(int'($urandom_range(14))), fw, mw, rz(), 1'b0, "rnd");
        end
        run_instr(32'hAC220008, 0, 1, 1'b0, 1'b1, "sw_rst2");
        run_instr(32'h3C010001, 0, 0, 1'b0, 1'b0, "lui");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
